sync_updown_counter: RTL

Parametrised synchronous binary counter, the successor to the team's fixed 2-bit up counter. It generalises width and modulus and adds several controls: up/down direction, count enable, synchronous clear, parallel load, and a wrap or saturate mode. It provides a combinational terminal-count flag for cascading and a registered one-cycle wrap pulse. It is the standard counting primitive for dividers, timers and sequence generators in the design.

---
 rtl/sync_updown_counter_if.sv | 25 ++
 rtl/sync_updown_counter.sv | 62 ++++++
 2 files changed

// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for sync_updown_counter; the master drives controls,
// the slave (the counter) returns the count, terminal-count flag and wrap pulse.
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             sat;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, sat, clear, load, load_val,
    input  Q, tc, wrap
  );

  modport slave (
    input  en, up_dn, sat, clear, load, load_val,
    output Q, tc, wrap
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Parametrised up/down modulus counter with clear, clamped load, wrap/saturate
// mode, combinational terminal count for cascading and a registered wrap pulse.
module sync_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  sync_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == ZERO);

  // Priority: clear, load, count, hold; wrap only pulses on a real rollover.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
    end else if (bus.clear) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      wrap_q  <= 1'b0;
    end else if (bus.en) begin
      wrap_q <= 1'b0;
      if (bus.up_dn) begin
        if (!at_max) begin
          count_q <= count_q + ONE;
        end else if (!bus.sat) begin
          count_q <= ZERO;
          wrap_q  <= 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_q <= count_q - ONE;
        end else if (!bus.sat) begin
          count_q <= MAX_VAL;
          wrap_q  <= 1'b1;
        end
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // tc ignores sat/clear/load so it can feed the next stage's enable directly.
  assign bus.tc   = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
  assign bus.Q    = count_q;
  assign bus.wrap = wrap_q;

endmodule
